// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone generator for the seven solfege notes
// (do..si) plus a rest, with an octave up-shift. Note, octave (and duty)
// are only sampled at period boundaries, so changes and stops never
// produce runt pulses.
//
// Optional feature macro: NOTE_TONE_DUTY_EN adds the duty[1:0] input that
// selects the high time of each period.
//
// Ports:
//   clock_in      system clock
//   reset         synchronous, active-high reset
//   enable        level-sensitive play request
//   note_sel      0=do 1=re 2=mi 3=fa 4=sol 5=la 6=si 7=rest
//   octave        octave up-shift (period right-shifted by this value)
//   duty          (NOTE_TONE_DUTY_EN only) 00=1/2 01=1/4 10=1/8 11=3/4
//   tone_out      registered square wave
//   period_start  one-cycle pulse on the first cycle of each tone period
//   active        high while playing or resting
//   cur_note      note currently latched
module note_tone_gen #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned CNT_W  = 28,
   parameter int unsigned OCT_W  = 2
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       note_sel,
   input  logic [OCT_W-1:0] octave,
`ifdef NOTE_TONE_DUTY_EN
   input  logic [1:0]       duty,
`endif
   output logic             tone_out,
   output logic             period_start,
   output logic             active,
   output logic [2:0]       cur_note
);

   localparam logic [2:0] NOTE_REST = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_REST = 2'd2;

   // Base periods in clocks, from note frequencies in centi-Hz
   localparam logic [63:0]      CLK_X100 = 64'(CLK_HZ) * 64'd100;
   localparam logic [CNT_W-1:0] P_DO  = CNT_W'(CLK_X100 / 64'd26163);
   localparam logic [CNT_W-1:0] P_RE  = CNT_W'(CLK_X100 / 64'd29366);
   localparam logic [CNT_W-1:0] P_MI  = CNT_W'(CLK_X100 / 64'd32963);
   localparam logic [CNT_W-1:0] P_FA  = CNT_W'(CLK_X100 / 64'd34923);
   localparam logic [CNT_W-1:0] P_SOL = CNT_W'(CLK_X100 / 64'd39200);
   localparam logic [CNT_W-1:0] P_LA  = CNT_W'(CLK_X100 / 64'd44000);
   localparam logic [CNT_W-1:0] P_SI  = CNT_W'(CLK_X100 / 64'd49388);

   function automatic logic [CNT_W-1:0] base_period(input logic [2:0] n);
      case (n)
         3'd0:    return P_DO;
         3'd1:    return P_RE;
         3'd2:    return P_MI;
         3'd3:    return P_FA;
         3'd4:    return P_SOL;
         3'd5:    return P_LA;
         3'd6:    return P_SI;
         default: return '0;
      endcase
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OCT_W-1:0] oct_q, oct_d;
   logic [2:0]       note_d;
   logic             tone_d, ps_d, active_d;
   logic             do_load;
   logic [CNT_W-1:0] period, high_cnt, cnt_inc;
   logic             last_cycle;
`ifdef NOTE_TONE_DUTY_EN
   logic [1:0]       duty_q, duty_d;
`endif

   // Period and high time of the latched note
   always_comb begin
      period   = base_period(cur_note) >> oct_q;
      high_cnt = period >> 1;
`ifdef NOTE_TONE_DUTY_EN
      case (duty_q)
         2'b00:   high_cnt = period >> 1;
         2'b01:   high_cnt = period >> 2;
         2'b10:   high_cnt = period >> 3;
         default: high_cnt = period - (period >> 2);
      endcase
      // Very short periods must still produce a high phase
      if (high_cnt == '0) high_cnt = CNT_W'(1);
`endif
      cnt_inc    = cnt_q + CNT_W'(1);
      last_cycle = (cnt_q == period - CNT_W'(1));
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      note_d  = cur_note;
      oct_d   = oct_q;
`ifdef NOTE_TONE_DUTY_EN
      duty_d  = duty_q;
`endif
      tone_d  = 1'b0;
      ps_d    = 1'b0;
      do_load = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable) do_load = 1'b1;
         end
         S_PLAY: begin
            if (last_cycle) begin
               if (enable) begin
                  do_load = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d  = cnt_inc;
               tone_d = (cnt_inc < high_cnt);
            end
         end
         S_REST: begin
            // Selections track the inputs while resting
            note_d = note_sel;
            oct_d  = octave;
`ifdef NOTE_TONE_DUTY_EN
            duty_d = duty;
`endif
            if (!enable)                    state_d = S_IDLE;
            else if (note_sel != NOTE_REST) do_load = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Load: latch the selection and start a period (or a rest)
      if (do_load) begin
         note_d = note_sel;
         oct_d  = octave;
`ifdef NOTE_TONE_DUTY_EN
         duty_d = duty;
`endif
         cnt_d  = '0;
         if (note_sel == NOTE_REST) begin
            state_d = S_REST;
         end else begin
            state_d = S_PLAY;
            tone_d  = 1'b1;
            ps_d    = 1'b1;
         end
      end

      active_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         oct_q        <= '0;
         cur_note     <= 3'd0;
         tone_out     <= 1'b0;
         period_start <= 1'b0;
         active       <= 1'b0;
`ifdef NOTE_TONE_DUTY_EN
         duty_q       <= 2'b00;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         oct_q        <= oct_d;
         cur_note     <= note_d;
         tone_out     <= tone_d;
         period_start <= ps_d;
         active       <= active_d;
`ifdef NOTE_TONE_DUTY_EN
         duty_q       <= duty_d;
`endif
      end
   end

   // A played period shorter than two clocks cannot form a square wave
   period_legal: assert property (@(posedge clock_in) disable iff (reset)
      (state_q == S_PLAY) |-> (period >= CNT_W'(2)));

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed bench for note_tone_gen at CLK_HZ=100_000.
module tb_note_tone_gen;

   logic       clock_in = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] note_sel;
   logic [1:0] octave;
`ifdef NOTE_TONE_DUTY_EN
   logic [1:0] duty;
`endif
   logic       tone_out;
   logic       period_start;
   logic       active;
   logic [2:0] cur_note;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock_in = ~clock_in;

   note_tone_gen #(
      .CLK_HZ(100_000),
      .CNT_W (28),
      .OCT_W (2)
   ) dut (
      .clock_in    (clock_in),
      .reset       (reset),
      .enable      (enable),
      .note_sel    (note_sel),
      .octave      (octave),
`ifdef NOTE_TONE_DUTY_EN
      .duty        (duty),
`endif
      .tone_out    (tone_out),
      .period_start(period_start),
      .active      (active),
      .cur_note    (cur_note)
   );

   // Advance one clock; inputs are driven and outputs sampled at negedge
   task automatic step();
      @(negedge clock_in);
   endtask

   // Called at a negedge showing period_start; returns high and low lengths
   // and leaves time at the next period_start (or at the bound)
   task automatic measure(output int hi, output int lo);
      hi = 0;
      lo = 0;
      while (tone_out === 1'b1 && hi < 5000) begin
         hi++;
         step();
      end
      while (tone_out !== 1'b1 && period_start !== 1'b1 && lo < 5000) begin
         lo++;
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; note_sel = 3'd0; octave = 2'd0;
`ifdef NOTE_TONE_DUTY_EN
      duty = 2'b00;
`endif
      repeat (3) step();
      reset = 1'b0;
      step();
      n_tests++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL reset_tone: got %b expected 0", tone_out); end
      n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b expected 0", period_start); end
      n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
      n_tests++; if (cur_note !== 3'd0) begin n_fail++; $display("FAIL reset_note: got %0d expected 0", cur_note); end
   endtask

   task automatic test_la();
      int hi, lo;
      note_sel = 3'd5; octave = 2'd0; enable = 1'b1;
      step();
      n_tests++; if (tone_out !== 1'b1) begin n_fail++; $display("FAIL la_latency_tone: got %b expected 1", tone_out); end
      n_tests++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL la_latency_ps: got %b expected 1", period_start); end
      n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL la_active: got %b expected 1", active); end
      n_tests++; if (cur_note !== 3'd5) begin n_fail++; $display("FAIL la_note: got %0d expected 5", cur_note); end
      measure(hi, lo);
      n_tests++; if (hi !== 113) begin n_fail++; $display("FAIL la_hi1: got %0d expected 113", hi); end
      n_tests++; if (lo !== 114) begin n_fail++; $display("FAIL la_lo1: got %0d expected 114", lo); end
      measure(hi, lo);
      n_tests++; if (hi !== 113) begin n_fail++; $display("FAIL la_hi2: got %0d expected 113", hi); end
      n_tests++; if (lo !== 114) begin n_fail++; $display("FAIL la_lo2: got %0d expected 114", lo); end
   endtask

   task automatic test_re_octave();
      int hi, lo;
      note_sel = 3'd1;
      measure(hi, lo);
      n_tests++; if (hi + lo !== 227) begin n_fail++; $display("FAIL re_la_finish: got %0d expected 227", hi + lo); end
      measure(hi, lo);
      n_tests++; if (hi !== 170) begin n_fail++; $display("FAIL re_hi: got %0d expected 170", hi); end
      n_tests++; if (lo !== 170) begin n_fail++; $display("FAIL re_lo: got %0d expected 170", lo); end
      octave = 2'd1;
      measure(hi, lo);
      measure(hi, lo);
      n_tests++; if (hi !== 85) begin n_fail++; $display("FAIL re_oct1_hi: got %0d expected 85", hi); end
      n_tests++; if (lo !== 85) begin n_fail++; $display("FAIL re_oct1_lo: got %0d expected 85", lo); end
      octave = 2'd0;
   endtask

   task automatic test_change_mid();
      int hi, lo, len, hsum;
      note_sel = 3'd5;
      measure(hi, lo);
      len = 0; hsum = 0;
      do begin
         if (len == 50) note_sel = 3'd6;
         if (tone_out === 1'b1) hsum++;
         len++;
         step();
      end while (period_start !== 1'b1 && len < 1000);
      n_tests++; if (len !== 227) begin n_fail++; $display("FAIL mid_la_len: got %0d expected 227", len); end
      n_tests++; if (hsum !== 113) begin n_fail++; $display("FAIL mid_la_hi: got %0d expected 113", hsum); end
      measure(hi, lo);
      n_tests++; if (hi !== 101) begin n_fail++; $display("FAIL mid_si_hi: got %0d expected 101", hi); end
      n_tests++; if (lo !== 101) begin n_fail++; $display("FAIL mid_si_lo: got %0d expected 101", lo); end
   endtask

   task automatic test_drop_enable();
      int hi, lo, len, pulses, highs;
      note_sel = 3'd5;
      measure(hi, lo);
      len = 0;
      while (active === 1'b1 && len < 1000) begin
         if (len == 10) enable = 1'b0;
         len++;
         step();
      end
      n_tests++; if (len !== 227) begin n_fail++; $display("FAIL drop_len: got %0d expected 227", len); end
      n_tests++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL drop_tone: got %b expected 0", tone_out); end
      pulses = 0; highs = 0;
      repeat (300) begin
         if (period_start === 1'b1) pulses++;
         if (tone_out !== 1'b0 || active !== 1'b0) highs++;
         step();
      end
      n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL drop_ps: got %0d expected 0", pulses); end
      n_tests++; if (highs !== 0) begin n_fail++; $display("FAIL drop_idle: got %0d expected 0", highs); end
   endtask

   task automatic test_rest();
      int hi, lo, len, highs;
      note_sel = 3'd7; enable = 1'b1;
      step();
      n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL rest_active: got %b expected 1", active); end
      n_tests++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL rest_tone: got %b expected 0", tone_out); end
      n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rest_ps: got %b expected 0", period_start); end
      n_tests++; if (cur_note !== 3'd7) begin n_fail++; $display("FAIL rest_note: got %0d expected 7", cur_note); end
      highs = 0;
      repeat (5) begin
         step();
         if (tone_out !== 1'b0 || period_start !== 1'b0) highs++;
      end
      n_tests++; if (highs !== 0) begin n_fail++; $display("FAIL rest_quiet: got %0d expected 0", highs); end
      note_sel = 3'd3;
      step();
      n_tests++; if (tone_out !== 1'b1) begin n_fail++; $display("FAIL fa_tone: got %b expected 1", tone_out); end
      n_tests++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL fa_ps: got %b expected 1", period_start); end
      n_tests++; if (cur_note !== 3'd3) begin n_fail++; $display("FAIL fa_note: got %0d expected 3", cur_note); end
      measure(hi, lo);
      n_tests++; if (hi !== 143) begin n_fail++; $display("FAIL fa_hi: got %0d expected 143", hi); end
      n_tests++; if (lo !== 143) begin n_fail++; $display("FAIL fa_lo: got %0d expected 143", lo); end
      // Rest selected while playing takes effect at the boundary without a pulse
      note_sel = 3'd7;
      len = 0;
      do begin
         len++;
         step();
      end while (cur_note !== 3'd7 && len < 1000);
      n_tests++; if (len !== 286) begin n_fail++; $display("FAIL play_rest_len: got %0d expected 286", len); end
      n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL play_rest_ps: got %b expected 0", period_start); end
      n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL play_rest_active: got %b expected 1", active); end
   endtask

   task automatic test_reset_mid();
      note_sel = 3'd5;
      step();
      repeat (30) step();
      n_tests++; if (tone_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_tone: got %b expected 1", tone_out); end
      reset = 1'b1;
      step();
      n_tests++; if (tone_out !== 1'b0) begin n_fail++; $display("FAIL rmid_tone: got %b expected 0", tone_out); end
      n_tests++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rmid_ps: got %b expected 0", period_start); end
      n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL rmid_active: got %b expected 0", active); end
      n_tests++; if (cur_note !== 3'd0) begin n_fail++; $display("FAIL rmid_note: got %0d expected 0", cur_note); end
      enable = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

`ifdef NOTE_TONE_DUTY_EN
   task automatic test_duty();
      int hi, lo;
      duty = 2'b01; note_sel = 3'd5; octave = 2'd0; enable = 1'b1;
      step();
      measure(hi, lo);
      n_tests++; if (hi !== 56) begin n_fail++; $display("FAIL duty01_hi: got %0d expected 56", hi); end
      n_tests++; if (lo !== 171) begin n_fail++; $display("FAIL duty01_lo: got %0d expected 171", lo); end
      duty = 2'b11;
      measure(hi, lo);
      measure(hi, lo);
      n_tests++; if (hi !== 171) begin n_fail++; $display("FAIL duty11_hi: got %0d expected 171", hi); end
      n_tests++; if (lo !== 56) begin n_fail++; $display("FAIL duty11_lo: got %0d expected 56", lo); end
      duty = 2'b10;
      measure(hi, lo);
      measure(hi, lo);
      n_tests++; if (hi !== 28) begin n_fail++; $display("FAIL duty10_hi: got %0d expected 28", hi); end
      n_tests++; if (lo !== 199) begin n_fail++; $display("FAIL duty10_lo: got %0d expected 199", lo); end
      enable = 1'b0;
      duty = 2'b00;
   endtask
`endif

   initial begin
      test_reset();
      test_la();
      test_re_octave();
      test_change_mid();
      test_drop_enable();
      test_rest();
      test_reset_mid();
`ifdef NOTE_TONE_DUTY_EN
      test_duty();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
